colparity_seq: RTL and testbench
================================

# colparity_seq

Sequencing controller for the column-parity datapath. Accepts a start request with a frame count, then, for each frame, clears the input/parity registers, loads 25 lanes from the input source, steps the parity register through 64 slices, and writes the result to the output sink. It replaces the free-running single-frame control unit with a handshaked, stall-aware, multi-frame scheduler that drives the datapath's control strobes directly.

## Interface
- LANES, 25, lanes loaded per frame (5x5 state)
- SLICES, 64, slice steps per frame
- FW, 8, width of frame count
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- num_frames  input  FW  frames to process; latched on accepted start
- in_valid  input  1  source has a lane available this cycle
- out_ready  input  1  sink accepts the write this cycle
- rst_in_reg  output  1  clear input and parity registers
- read_input  output  1  lane read strobe (qualified by in_valid)
- ld_ppr  output  1  parity register load for current slice
- write_input  output  1  result write strobe (qualified by out_ready)
- lane_idx  output  5  current lane, 0..LANES-1
- slice_idx  output  6  current slice, 0..SLICES-1
- frame_idx  output  FW  current frame, 0-based
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the run finishes

## Operation
- States: IDLE, CLEAR, LOAD, STEP, WRITE, FIN.
- IDLE: when start=1, latch num_frames and zero frame_idx. If num_frames=0, go to FIN; otherwise go to CLEAR. While busy, start is ignored and has no queued effect.
- CLEAR: one cycle with rst_in_reg=1. Clear lane_idx and slice_idx, then go to LOAD.
- LOAD: read_input = in_valid. An accepted read advances lane_idx. The read at lane_idx=LANES-1 moves to STEP. With in_valid=0 the state holds and lane_idx holds.
- STEP: ld_ppr=1 every cycle and slice_idx advances. At slice_idx=SLICES-1, go to WRITE. STEP cannot stall.
- WRITE: write_input = out_ready. On an accepted write, if frame_idx = latched count - 1, go to FIN. Otherwise increment frame_idx and go to CLEAR. With out_ready=0 the state holds.
- FIN: done=1 for one cycle, then go to IDLE.
- Counters wrap only by explicit clear. lane_idx never exceeds LANES-1, and slice_idx never exceeds SLICES-1.
- At most one strobe is high in any cycle. Strobes are decoded from the registered state plus the handshake input only.

## Timing
- Reset (rst=0 at a clock edge), including mid-run: state becomes IDLE, and all outputs and indices become 0. No done pulse is produced.
- Start to first rst_in_reg: 1 cycle (start is sampled at edge N, CLEAR is active during cycle N+1).
- Per frame with no stalls: 1 (CLEAR) + LANES (LOAD) + SLICES (STEP) + 1 (WRITE) = 91 cycles.
- The done pulse occurs the cycle after the last accepted write. busy falls together with the cycle after done.
- num_frames=0: done is asserted 1 cycle after start, and no strobes fire.
- num_frames is sampled only at start. Changes during a run are ignored.

## Configuration
- COLPARITY_ABORT_EN: when defined, the block adds an input port abort (1 bit).
  - abort=1 in any non-IDLE state forces IDLE on the next edge.
  - All strobes are 0 in the abort cycle's successor, and done is not pulsed.
  - If abort coincides with an accepted final write, abort wins: the write strobe still fires that cycle, but done is suppressed.
  - abort in IDLE has no effect.
- When not defined, the abort port does not exist and runs always complete.

## Test plan
- Reset, then start with num_frames=1 and in_valid=out_ready=1 held: rst_in_reg for 1 cycle, 25 read_input cycles (lane_idx 0..24), 64 ld_ppr cycles (slice_idx 0..63), 1 write_input, done exactly 91+1 cycles after start, then busy=0.
- num_frames=3, no stalls: 3 write_input pulses spaced 91 cycles apart, frame_idx 0→1→2, and a single done pulse.
- in_valid low for 5 cycles at lane_idx=10 and out_ready low for 3 cycles in WRITE: lane_idx holds at 10, write_input is 0 while out_ready=0, and total latency grows to 99 cycles.
- num_frames=0: done 1 cycle after start, with no rst_in_reg, read_input, ld_ppr or write_input. A start asserted mid-run is ignored, and frame count and latency are unchanged.
- rst=0 applied during STEP at slice_idx=30: the next cycle shows all outputs 0 and state IDLE, with no done. A fresh start then runs a full 91-cycle frame.
- With COLPARITY_ABORT_EN, abort=1 during LOAD at lane_idx=7: the next cycle has busy=0, no done, and no further strobes.

Source files
------------

// File: rtl/colparity_seq_if.sv
// Handshake/strobe bundle between the column-parity sequencer and its environment.
// The abort input exists only when COLPARITY_ABORT_EN is defined.
interface colparity_seq_if #(
  parameter int FW = 8
);
  logic          start;
  logic [FW-1:0] num_frames;
  logic          in_valid;
  logic          out_ready;
  logic          rst_in_reg;
  logic          read_input;
  logic          ld_ppr;
  logic          write_input;
  logic [4:0]    lane_idx;
  logic [5:0]    slice_idx;
  logic [FW-1:0] frame_idx;
  logic          busy;
  logic          done;
`ifdef COLPARITY_ABORT_EN
  logic          abort;

  modport slave (
    input  start, num_frames, in_valid, out_ready, abort,
    output rst_in_reg, read_input, ld_ppr, write_input,
           lane_idx, slice_idx, frame_idx, busy, done
  );

  modport master (
    output start, num_frames, in_valid, out_ready, abort,
    input  rst_in_reg, read_input, ld_ppr, write_input,
           lane_idx, slice_idx, frame_idx, busy, done
  );
`else
  modport slave (
    input  start, num_frames, in_valid, out_ready,
    output rst_in_reg, read_input, ld_ppr, write_input,
           lane_idx, slice_idx, frame_idx, busy, done
  );

  modport master (
    output start, num_frames, in_valid, out_ready,
    input  rst_in_reg, read_input, ld_ppr, write_input,
           lane_idx, slice_idx, frame_idx, busy, done
  );
`endif
endinterface

// File: rtl/colparity_seq.sv
// Multi-frame scheduler for the column-parity datapath: clear, load lanes, step slices, write.
// Optional abort input enabled by defining COLPARITY_ABORT_EN.
module colparity_seq #(
  parameter int LANES  = 25,
  parameter int SLICES = 64,
  parameter int FW     = 8
) (
  input  logic           clk,
  input  logic           rst,
  colparity_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_STEP, S_WRITE, S_FIN
  } state_e;

  localparam logic [4:0]    LAST_LANE  = 5'(LANES - 1);
  localparam logic [5:0]    LAST_SLICE = 6'(SLICES - 1);
  localparam logic [FW-1:0] ONE        = FW'(1);

  state_e        r_state;
  state_e        w_next;
  logic [4:0]    r_lane;
  logic [5:0]    r_slice;
  logic [FW-1:0] r_frame;
  logic [FW-1:0] r_count;
  logic          w_last_frame;
  logic          w_abort;

`ifdef COLPARITY_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last_frame = (r_frame == r_count - ONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_lane  <= '0;
      r_slice <= '0;
      r_frame <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_count <= bus.num_frames;
            r_frame <= '0;
          end
        end
        S_CLEAR: begin
          r_lane  <= '0;
          r_slice <= '0;
        end
        S_LOAD: begin
          if (bus.in_valid && r_lane != LAST_LANE) r_lane <= r_lane + 5'd1;
        end
        S_STEP: begin
          if (r_slice != LAST_SLICE) r_slice <= r_slice + 6'd1;
        end
        S_WRITE: begin
          if (bus.out_ready && !w_last_frame) r_frame <= r_frame + ONE;
        end
        default: ;
      endcase
    end
  end

  // Strobes depend only on the registered state and the handshake inputs.
  always_comb begin
    w_next          = r_state;
    bus.rst_in_reg  = 1'b0;
    bus.read_input  = 1'b0;
    bus.ld_ppr      = 1'b0;
    bus.write_input = 1'b0;
    bus.done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (bus.num_frames == '0) ? S_FIN : S_CLEAR;
      end
      S_CLEAR: begin
        bus.rst_in_reg = 1'b1;
        w_next         = S_LOAD;
      end
      S_LOAD: begin
        bus.read_input = bus.in_valid;
        if (bus.in_valid && r_lane == LAST_LANE) w_next = S_STEP;
      end
      S_STEP: begin
        bus.ld_ppr = 1'b1;
        if (r_slice == LAST_SLICE) w_next = S_WRITE;
      end
      S_WRITE: begin
        bus.write_input = bus.out_ready;
        if (bus.out_ready) w_next = w_last_frame ? S_FIN : S_CLEAR;
      end
      S_FIN: begin
        bus.done = !w_abort;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort overrides everything, including a final write going to FIN.
    if (w_abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  assign bus.lane_idx  = r_lane;
  assign bus.slice_idx = r_slice;
  assign bus.frame_idx = r_frame;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_colparity_seq.sv
// Randomized bench for colparity_seq: a queue of expected per-frame events acts as the reference.
// Abort scenario compiled only with COLPARITY_ABORT_EN.
module tb_colparity_seq;

  typedef enum int {EV_CLEAR, EV_READ, EV_STEP, EV_WRITE, EV_DONE} evKind_e;
  typedef struct {
    evKind_e kind;
    int      idx;
    int      frame;
  } ev_t;

  logic clk;
  logic rst;
  int   vecCount;
  int   failCount;
  ev_t  expQ[$];

  colparity_seq_if #(.FW(8)) cif ();

  colparity_seq #(.LANES(25), .SLICES(64), .FW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [5:0] obsStrobes();
    return {cif.rst_in_reg, cif.read_input, cif.ld_ppr, cif.write_input, cif.done, cif.busy};
  endfunction

  // {clear, read, step, write, done, busy} expected for one event.
  function automatic logic [5:0] expStrobes(input evKind_e k, input bit stalled);
    if (stalled) return 6'b000001;
    case (k)
      EV_CLEAR: return 6'b100001;
      EV_READ:  return 6'b010001;
      EV_STEP:  return 6'b001001;
      EV_WRITE: return 6'b000101;
      default:  return 6'b000011;
    endcase
  endfunction

  task automatic buildQueue(input int frames);
    expQ.delete();
    for (int f = 0; f < frames; f++) begin
      expQ.push_back('{EV_CLEAR, 0, f});
      for (int l = 0; l < 25; l++) expQ.push_back('{EV_READ, l, f});
      for (int s = 0; s < 64; s++) expQ.push_back('{EV_STEP, s, f});
      expQ.push_back('{EV_WRITE, 0, f});
    end
    expQ.push_back('{EV_DONE, 0, (frames > 0) ? frames - 1 : 0});
  endtask

  // mode 0: no stalls, 1: random stalls, 2: in_valid low 5 cycles at lane 10 and out_ready low 3 cycles.
  // interrupt 0: none, 1: reset at slice 30, 2: abort at lane 7.
  task automatic applyStimulus(input int frames, input int mode, input bit midStart, input int interrupt);
    int  k = 0;
    int  nStall = 0;
    int  doneOff = -1;
    int  inStall = 5;
    int  outStall = 3;
    int  writeOff[$];
    ev_t head;
    bit  stalled;
    bit  fired = 0;
    bit  iv;
    bit  ordy;
    buildQueue(frames);
    cif.num_frames = 8'(frames);
    cif.start      = 1'b1;
    @(posedge clk); #1;
    cif.start = 1'b0;
    while (expQ.size() > 0 && k < 5000) begin
      k++;
      head = expQ[0];
      iv   = 1'b1;
      ordy = 1'b1;
      if (mode == 1) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if (head.kind == EV_READ && head.idx == 10 && inStall > 0) begin
          iv = 1'b0;
          inStall--;
        end
        if (head.kind == EV_WRITE && outStall > 0) begin
          ordy = 1'b0;
          outStall--;
        end
      end
      cif.in_valid  = iv;
      cif.out_ready = ordy;
      if (midStart) begin
        cif.start      = 1'($urandom_range(0, 1));
        cif.num_frames = 8'($urandom_range(0, 255));
      end
      if (interrupt == 1 && head.kind == EV_STEP && head.idx == 30) begin
        rst   = 1'b0;
        fired = 1'b1;
      end
`ifdef COLPARITY_ABORT_EN
      if (interrupt == 2 && head.kind == EV_READ && head.idx == 7) begin
        cif.abort = 1'b1;
        fired     = 1'b1;
      end
`endif
      @(negedge clk);
      stalled = (head.kind == EV_READ && !iv) || (head.kind == EV_WRITE && !ordy);
      checkOutput("strobes", 32'(obsStrobes()), 32'(expStrobes(head.kind, stalled)));
      checkOutput("frame_idx", 32'(cif.frame_idx), 32'(head.frame));
      if (head.kind == EV_READ) checkOutput("lane_idx", 32'(cif.lane_idx), 32'(head.idx));
      if (head.kind == EV_STEP) checkOutput("slice_idx", 32'(cif.slice_idx), 32'(head.idx));
      if (stalled) nStall++;
      else begin
        void'(expQ.pop_front());
        if (head.kind == EV_WRITE) writeOff.push_back(k);
        if (head.kind == EV_DONE) doneOff = k;
      end
      @(posedge clk); #1;
      if (fired) break;
    end
    cif.start = 1'b0;
    if (fired) begin
      rst = 1'b1;
`ifdef COLPARITY_ABORT_EN
      cif.abort = 1'b0;
`endif
      @(negedge clk);
      checkOutput("interrupt_quiet", 32'(obsStrobes()), 32'd0);
      if (interrupt == 1)
        checkOutput("reset_indices", {cif.lane_idx, cif.slice_idx, cif.frame_idx}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("interrupt_no_done", 32'(obsStrobes()), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (expQ.size() > 0) begin
      checkOutput("timeout", 32'(expQ.size()), 32'd0);
      return;
    end
    checkOutput("done_latency", 32'(doneOff), 32'((frames == 0) ? 1 : 1 + 91 * frames + nStall));
    checkOutput("write_count", 32'(writeOff.size()), 32'(frames));
    if (mode == 0)
      for (int i = 0; i < writeOff.size(); i++)
        checkOutput("write_spacing", 32'(writeOff[i]), 32'(91 * (i + 1)));
    if (mode == 2 && writeOff.size() > 0)
      checkOutput("stalled_write", 32'(writeOff[0]), 32'd99);
    @(negedge clk);
    checkOutput("idle_after_run", 32'(obsStrobes()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecCount       = 0;
    failCount      = 0;
    rst            = 1'b0;
    cif.start      = 1'b0;
    cif.num_frames = '0;
    cif.in_valid   = 1'b1;
    cif.out_ready  = 1'b1;
`ifdef COLPARITY_ABORT_EN
    cif.abort      = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset_strobes", 32'(obsStrobes()), 32'd0);
    checkOutput("reset_indices", {cif.lane_idx, cif.slice_idx, cif.frame_idx}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single frame, no stalls");
    applyStimulus(1, 0, 1'b0, 0);
    $display("[TB] three frames, no stalls");
    applyStimulus(3, 0, 1'b0, 0);
    $display("[TB] directed stalls");
    applyStimulus(1, 2, 1'b0, 0);
    $display("[TB] zero frames");
    applyStimulus(0, 0, 1'b0, 0);
    $display("[TB] start toggled mid-run");
    applyStimulus(2, 0, 1'b1, 0);
    $display("[TB] reset during STEP");
    applyStimulus(1, 0, 1'b0, 1);
    applyStimulus(1, 0, 1'b0, 0);
`ifdef COLPARITY_ABORT_EN
    $display("[TB] abort during LOAD");
    applyStimulus(2, 0, 1'b0, 2);
    applyStimulus(1, 0, 1'b0, 0);
`endif
    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++)
      applyStimulus(int'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
